// File: rtl/ex_muldiv_unit.sv
// Multi-cycle MIPS-style multiply/divide unit holding HI/LO (shift-add multiply, restoring divide).
// Optional macro FAST_MUL_EN: single-cycle combinational multiply; divide path unchanged.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic [2*XLEN-1:0]   acc_reg;   // mul: {partial product, multiplier}; div: low half holds quotient
  logic [XLEN:0]       rem_reg;
  logic [XLEN-1:0]     opnd_reg, orig_a_reg, hi_reg, lo_reg;
  logic                is_div_reg, neg_res_reg, neg_rem_reg, div0_reg, done_reg;

  logic                accept, is_arith, op_div, op_uns, a_neg, b_neg, commit;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [XLEN:0]       mul_sum, div_sh, div_rem_next;
  logic                div_ge;
  logic [2*XLEN-1:0]   prod, prod_fix;
  logic [XLEN-1:0]     q_val, r_val, res_hi, res_lo;

  assign accept   = (state_reg == IDLE) && i_start && !i_flush;
  assign is_arith = !i_op[2];
  assign op_div   = i_op[1];
  assign op_uns   = i_op[0];
  assign a_neg    = !op_uns && i_a[XLEN-1];
  assign b_neg    = !op_uns && i_b[XLEN-1];
  assign a_mag    = a_neg ? (~i_a + 1'b1) : i_a;
  assign b_mag    = b_neg ? (~i_b + 1'b1) : i_b;
  assign commit   = (state_reg == FIX) && !i_flush;

  // One iteration of each algorithm; the divisor/multiplicand lives in opnd_reg.
  assign mul_sum      = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
  assign div_sh       = {rem_reg[XLEN-1:0], acc_reg[XLEN-1]};
  assign div_ge       = div_sh >= {1'b0, opnd_reg};
  assign div_rem_next = div_ge ? (div_sh - {1'b0, opnd_reg}) : div_sh;

`ifdef FAST_MUL_EN
  assign prod = {{XLEN{1'b0}}, opnd_reg} * {{XLEN{1'b0}}, acc_reg[XLEN-1:0]};
`else
  assign prod = acc_reg;
`endif
  assign prod_fix = neg_res_reg ? (~prod + 1'b1) : prod;
  assign q_val    = acc_reg[XLEN-1:0];
  assign r_val    = rem_reg[XLEN-1:0];

  always_comb begin
    res_hi = prod_fix[2*XLEN-1:XLEN];
    res_lo = prod_fix[XLEN-1:0];
    if (is_div_reg) begin
      if (div0_reg) begin
        res_hi = orig_a_reg;
        res_lo = '1;
      end else begin
        res_hi = neg_rem_reg ? (~r_val + 1'b1) : r_val;
        res_lo = neg_res_reg ? (~q_val + 1'b1) : q_val;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept && is_arith) begin
`ifdef FAST_MUL_EN
          state_next = op_div ? RUN : FIX;
`else
          state_next = RUN;
`endif
        end
      end
      RUN: begin
        if (i_flush)
          state_next = IDLE;
        else if (cnt_reg == CNT_W'(XLEN-1))
          state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      rem_reg     <= '0;
      opnd_reg    <= '0;
      orig_a_reg  <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      is_div_reg  <= 1'b0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      div0_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= commit;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (is_arith) begin
              cnt_reg     <= '0;
              rem_reg     <= '0;
              is_div_reg  <= op_div;
              neg_res_reg <= a_neg ^ b_neg;
              neg_rem_reg <= a_neg;
              div0_reg    <= (i_b == '0);
              orig_a_reg  <= i_a;
              if (op_div) begin
                acc_reg  <= {{XLEN{1'b0}}, a_mag};
                opnd_reg <= b_mag;
              end else begin
                acc_reg  <= {{XLEN{1'b0}}, b_mag};
                opnd_reg <= a_mag;
              end
            end else if (i_op == 3'b100) begin
              hi_reg <= i_a;
            end else if (i_op == 3'b101) begin
              lo_reg <= i_a;
            end
          end
        end
        RUN: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (is_div_reg) begin
            acc_reg <= {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-2:0], div_ge};
            rem_reg <= div_rem_next;
          end else begin
            acc_reg <= {mul_sum, acc_reg[XLEN-1:1]};
          end
        end
        FIX: begin
          if (commit) begin
            hi_reg <= res_hi;
            lo_reg <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (state_reg != IDLE);
  assign o_done = done_reg;
  assign o_hi   = hi_reg;
  assign o_lo   = lo_reg;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: random and directed ops against a plain-arithmetic HI/LO model.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, i_start, i_flush;
  logic [2:0]  i_op;
  logic [31:0] i_a, i_b;
  logic        o_busy, o_done;
  logic [31:0] o_hi, o_lo;

`ifdef FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_hi = '0, model_lo = '0;
  logic [63:0] mon_e;

  ex_muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_op(i_op), .i_a(i_a), .i_b(i_b),
    .i_flush(i_flush), .o_busy(o_busy), .o_done(o_done), .o_hi(o_hi), .o_lo(o_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Architectural reference: signed/unsigned 64-bit arithmetic, C-style truncating division.
  function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, p, q, r;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0;
    lo = '0;
    case (op)
      3'd0: begin p = sa * sb; {hi, lo} = p; end
      3'd1: begin up = {32'b0, a} * {32'b0, b}; {hi, lo} = up; end
      3'd2: begin
        if (b == 0) begin hi = a; lo = '1; end
        else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
      end
      3'd3: begin
        if (b == 0) begin hi = a; lo = '1; end
        else begin lo = a / b; hi = a % b; end
      end
      default: ;
    endcase
  endfunction

  // Monitor: every o_done pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && o_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got o_done=1 hi=%h lo=%h required no o_done", o_hi, o_lo);
        end else begin
          mon_e = exp_q.pop_front();
          $display("done: hi=%h lo=%h expected %h", o_hi, o_lo, mon_e);
          chk("result", {o_hi, o_lo}, mon_e);
        end
      end
    end
  end

  // Issue one op at the current negedge and wait (bounded) until it has finished.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    int n, lat;
    i_start = 1'b1; i_op = op; i_a = a; i_b = b;
    if (!op[2]) begin
      ref_model(op, a, b, eh, el);
      exp_q.push_back({eh, el});
      model_hi = eh;
      model_lo = el;
    end else if (op == 3'd4) begin
      model_hi = a;
    end else if (op == 3'd5) begin
      model_lo = a;
    end
    @(negedge clk);
    i_start = 1'b0;
    if (!op[2]) begin
      n = 0;
      while (o_busy && n < 100) begin
        n++;
        @(negedge clk);
      end
      lat = (FAST && !op[1]) ? 1 : 33;
      chk("busy_cycles", 64'(n), 64'(lat));
      chk("done_pulse", 64'(o_done), 64'd1);
    end else begin
      $display("op=%0d a=%h: hi=%h lo=%h", op, a, o_hi, o_lo);
      chk("busy_idle_op", 64'(o_busy), 64'd0);
      chk("hi_after_op", 64'(o_hi), 64'(model_hi));
      chk("lo_after_op", 64'(o_lo), 64'(model_lo));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b1; i_start = 1'b0; i_flush = 1'b0; i_op = '0; i_a = '0; i_b = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(o_busy), 64'd0);
    chk("reset_done", 64'(o_done), 64'd0);
    chk("reset_hilo", {o_hi, o_lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed results, with constants cross-checking the model
    run_op(3'd0, 32'hFFFF_FFFE, 32'h3);
    chk("mult_const", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(3'd2, 32'hFFFF_FFF9, 32'h2);
    chk("div_const", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd3, 32'd100, 32'd7);
    chk("divu_const", {o_hi, o_lo}, {32'd2, 32'd14});
    run_op(3'd3, 32'h1234, 32'h0);
    chk("divu_zero_const", {o_hi, o_lo}, {32'h1234, 32'hFFFF_FFFF});
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_const", {o_hi, o_lo}, {32'h0, 32'h8000_0000});
    run_op(3'd1, 32'h1_0000, 32'h1_0000);
    chk("multu_const", {o_hi, o_lo}, 64'h1_0000_0000);
    run_op(3'd2, 32'hFFFF_FF00, 32'h0);
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000);

    // MTHI then MTLO on back-to-back cycles
    i_start = 1'b1; i_op = 3'd4; i_a = 32'hCAFE_BABE;
    @(negedge clk);
    chk("mthi_hi", 64'(o_hi), 64'hCAFE_BABE);
    chk("mthi_busy", 64'(o_busy), 64'd0);
    i_op = 3'd5; i_a = 32'h0BAD_F00D;
    @(negedge clk);
    i_start = 1'b0;
    chk("mtlo_lo", 64'(o_lo), 64'h0BAD_F00D);
    chk("mtlo_hi_kept", 64'(o_hi), 64'hCAFE_BABE);
    chk("mtlo_busy", 64'(o_busy), 64'd0);
    model_hi = 32'hCAFE_BABE; model_lo = 32'h0BAD_F00D;
    $display("mthi/mtlo: hi=%h lo=%h", o_hi, o_lo);

    // Flush a DIV at busy cycle 20
    i_start = 1'b1; i_op = 3'd2; i_a = 32'd1000; i_b = 32'd3;
    @(negedge clk);
    i_start = 1'b0;
    repeat (19) @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    chk("flush_busy", 64'(o_busy), 64'd0);
    chk("flush_done", 64'(o_done), 64'd0);
    chk("flush_hilo", {o_hi, o_lo}, {model_hi, model_lo});
    $display("flush: hi=%h lo=%h", o_hi, o_lo);
    repeat (40) @(negedge clk);
    chk("flush_hilo_later", {o_hi, o_lo}, {model_hi, model_lo});

    // i_start pulsed while a DIVU is in flight must be ignored
    i_start = 1'b1; i_op = 3'd3; i_a = 32'd100; i_b = 32'd7;
    exp_q.push_back({32'd2, 32'd14});
    model_hi = 32'd2; model_lo = 32'd14;
    @(negedge clk);
    i_start = 1'b0;
    n = 0;
    while (o_busy && n < 100) begin
      n++;
      if (n == 5) begin i_start = 1'b1; i_op = 3'd0; i_a = 32'd9; i_b = 32'd9; end
      else i_start = 1'b0;
      @(negedge clk);
    end
    i_start = 1'b0;
    chk("busy_ignore_latency", 64'(n), 64'd33);
    repeat (40) @(negedge clk);
    chk("busy_ignore_idle", 64'(o_busy), 64'd0);

    // Randomized op mix
    for (int k = 0; k < 25; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      run_op(rop, ra, rb);
    end

    // Asynchronous reset in the middle of RUN
    i_start = 1'b1; i_op = FAST ? 3'd3 : 3'd1; i_a = 32'd3; i_b = 32'd5;
    @(negedge clk);
    i_start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset_busy", 64'(o_busy), 64'd0);
    chk("midreset_hilo", {o_hi, o_lo}, 64'd0);
    chk("midreset_done", 64'(o_done), 64'd0);
    model_hi = '0; model_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("midreset_hilo_later", {o_hi, o_lo}, 64'd0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
